// File: rtl/rocket_trace_pkg.sv
// Shared definitions for the retire-trace collector: counter widths, id width
// helper and the record bit layout that the monitor's unpacker also relies on.
package rocket_trace_pkg;

    localparam int DROP_CNT_W = 8;

    // Record layout, LSB first: lost, ts, insn, pc
    localparam int REC_LOST_LSB = 0;
    localparam int REC_TS_LSB   = 1;

    function automatic int core_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int rec_insn_lsb(input int ts_w);
        return REC_TS_LSB + ts_w;
    endfunction

    function automatic int rec_pc_lsb(input int ts_w, input int insn_w);
        return REC_TS_LSB + ts_w + insn_w;
    endfunction

    function automatic int rec_width(input int ts_w, input int insn_w, input int pc_w);
        return REC_TS_LSB + ts_w + insn_w + pc_w;
    endfunction

endpackage

// File: rtl/rocket_trace_fifo.sv
// Per-core first-word-fall-through FIFO. A push while full is accepted only
// when the head is popped in the same cycle.
module rocket_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests against the current occupancy
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
    end

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign dout  = mem_r[rd_ptr_r[AW-1:0]];

    // Storage array; contents are don't-care while empty so it needs no reset
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    // Read and write pointers with a wrap bit to tell full from empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/rocket_trace_mux.sv
// Multi-core retire-trace collector: timestamps retires into per-core FIFOs and
// merges them round-robin into one registered valid/ready record stream.
module rocket_trace_mux
    import rocket_trace_pkg::*;
#(
    parameter int N_CORES    = 4,
    parameter int PC_WIDTH   = 64,
    parameter int INSN_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_WIDTH   = 32,
    localparam int CORE_ID_W = core_id_w(N_CORES)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [N_CORES-1:0]             retire_valid,
    input  logic [N_CORES*PC_WIDTH-1:0]    retire_pc,
    input  logic [N_CORES*INSN_WIDTH-1:0]  retire_insn,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CORE_ID_W-1:0]           out_core,
    output logic [PC_WIDTH-1:0]            out_pc,
    output logic [INSN_WIDTH-1:0]          out_insn,
    output logic [TS_WIDTH-1:0]            out_ts,
    output logic                           out_lost,
    output logic [N_CORES*DROP_CNT_W-1:0]  drop_count
);

    localparam int REC_W    = rec_width(TS_WIDTH, INSN_WIDTH, PC_WIDTH);
    localparam int INSN_LSB = rec_insn_lsb(TS_WIDTH);
    localparam int PC_LSB   = rec_pc_lsb(TS_WIDTH, INSN_WIDTH);
    localparam logic [CORE_ID_W-1:0] LAST_CORE = CORE_ID_W'(N_CORES - 1);
    localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};

    logic [TS_WIDTH-1:0]   ts_r;
    logic [CORE_ID_W-1:0]  rr_ptr_r;
    logic [CORE_ID_W-1:0]  grant_s;
    logic [N_CORES-1:0]    empty_s;
    logic [N_CORES-1:0]    full_s;
    logic [N_CORES-1:0]    ne_s;
    logic [N_CORES-1:0]    push_s;
    logic [N_CORES-1:0]    pop_s;
    logic [N_CORES-1:0]    drop_s;
    logic [N_CORES-1:0]    lost_pending_r;
    logic [REC_W-1:0]      din_s  [N_CORES];
    logic [REC_W-1:0]      dout_s [N_CORES];
    logic [DROP_CNT_W-1:0] drop_cnt_r [N_CORES];
    logic [REC_W-1:0]      head_s;
    logic                  load_s;

    assign ne_s   = ~empty_s;
    assign load_s = (!out_valid || out_ready) && (|ne_s);
    assign head_s = dout_s[grant_s];

    // Round-robin pick: lowest non-empty index at or above rr_ptr wins,
    // otherwise fall back to the lowest non-empty index overall (wrap-around)
    always_comb begin
        grant_s = {CORE_ID_W{1'b0}};
        for (int i = N_CORES - 1; i >= 0; i--) begin
            grant_s = ne_s[i] ? CORE_ID_W'(i) : grant_s;
        end
        for (int i = N_CORES - 1; i >= 0; i--) begin
            grant_s = (ne_s[i] && (CORE_ID_W'(i) >= rr_ptr_r)) ? CORE_ID_W'(i) : grant_s;
        end
    end

    for (genvar g = 0; g < N_CORES; g++) begin : g_core
        assign pop_s[g]  = load_s && (grant_s == CORE_ID_W'(g));
        assign push_s[g] = enable && retire_valid[g] && (!full_s[g] || pop_s[g]);
        assign drop_s[g] = enable && retire_valid[g] && full_s[g] && !pop_s[g];
        assign din_s[g]  = {retire_pc[g*PC_WIDTH +: PC_WIDTH],
                            retire_insn[g*INSN_WIDTH +: INSN_WIDTH],
                            ts_r, lost_pending_r[g]};
        assign drop_count[g*DROP_CNT_W +: DROP_CNT_W] = drop_cnt_r[g];

        rocket_trace_fifo #(
            .WIDTH (REC_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push_s[g]),
            .pop   (pop_s[g]),
            .din   (din_s[g]),
            .dout  (dout_s[g]),
            .full  (full_s[g]),
            .empty (empty_s[g])
        );
    end

    // Free-running timestamp and round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_r     <= {TS_WIDTH{1'b0}};
            rr_ptr_r <= {CORE_ID_W{1'b0}};
        end else begin
            ts_r <= ts_r + TS_WIDTH'(1);
            if (load_s) begin
                rr_ptr_r <= (grant_s == LAST_CORE) ? {CORE_ID_W{1'b0}} : grant_s + CORE_ID_W'(1);
            end
        end
    end

    // Loss tracking: a drop arms lost_pending, the next accepted push carries and clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lost_pending_r <= {N_CORES{1'b0}};
            for (int i = 0; i < N_CORES; i++) begin
                drop_cnt_r[i] <= {DROP_CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                if (drop_s[i]) begin
                    lost_pending_r[i] <= 1'b1;
                    if (drop_cnt_r[i] != DROP_MAX) begin
                        drop_cnt_r[i] <= drop_cnt_r[i] + DROP_CNT_W'(1);
                    end
                end else if (push_s[i]) begin
                    lost_pending_r[i] <= 1'b0;
                end
            end
        end
    end

    // Output record register; only reloads when empty or being consumed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_core  <= {CORE_ID_W{1'b0}};
            out_pc    <= {PC_WIDTH{1'b0}};
            out_insn  <= {INSN_WIDTH{1'b0}};
            out_ts    <= {TS_WIDTH{1'b0}};
            out_lost  <= 1'b0;
        end else if (load_s) begin
            out_valid <= 1'b1;
            out_core  <= grant_s;
            out_pc    <= head_s[PC_LSB +: PC_WIDTH];
            out_insn  <= head_s[INSN_LSB +: INSN_WIDTH];
            out_ts    <= head_s[REC_TS_LSB +: TS_WIDTH];
            out_lost  <= head_s[REC_LOST_LSB];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rocket_trace_mux.sv
// Directed bench for rocket_trace_mux with a queue-based reference model
// compared every cycle, plus hand-computed expectations per scenario.
module tb_rocket_trace_mux;

    localparam int N     = 4;
    localparam int DEPTH = 8;

    typedef struct {
        int          core;
        logic [63:0] pc;
        logic [31:0] insn;
        logic [3:0]  ts;
        logic        lost;
    } rec_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic [N-1:0]   retire_valid;
    logic [N*64-1:0] retire_pc;
    logic [N*32-1:0] retire_insn;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     out_core;
    logic [63:0]    out_pc;
    logic [31:0]    out_insn;
    logic [3:0]     out_ts;
    logic           out_lost;
    logic [N*8-1:0] drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    rec_t mq [N][$];
    bit   m_lost_p [N];
    int   m_drop [N];
    int   m_ts = 0;
    int   m_rr = 0;
    bit   m_valid = 0;
    rec_t m_out;

    rec_t snap;
    bit   snap_valid = 0;
    rec_t xfer_q [$];

    rocket_trace_mux #(
        .N_CORES    (N),
        .PC_WIDTH   (64),
        .INSN_WIDTH (32),
        .FIFO_DEPTH (DEPTH),
        .TS_WIDTH   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .retire_insn  (retire_insn),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_core     (out_core),
        .out_pc       (out_pc),
        .out_insn     (out_insn),
        .out_ts       (out_ts),
        .out_lost     (out_lost),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mq[i].delete();
            m_lost_p[i] = 0;
            m_drop[i]   = 0;
        end
        m_ts = 0;
        m_rr = 0;
        m_valid = 0;
        m_out = '{0, 64'h0, 32'h0, 4'h0, 1'b0};
    endtask

    task automatic model_step();
        int   g;
        rec_t r;
        g = -1;
        if (!m_valid || out_ready) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_rr + k) % N;
                if (g < 0 && mq[c].size() > 0) g = c;
            end
        end
        if (g >= 0) begin
            m_out   = mq[g].pop_front();
            m_valid = 1;
            m_rr    = (g + 1) % N;
        end else if (out_ready) begin
            m_valid = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (enable && retire_valid[i]) begin
                if (mq[i].size() < DEPTH) begin
                    r.core = i;
                    r.pc   = retire_pc[i*64 +: 64];
                    r.insn = retire_insn[i*32 +: 32];
                    r.ts   = 4'(m_ts);
                    r.lost = m_lost_p[i];
                    mq[i].push_back(r);
                    m_lost_p[i] = 0;
                end else begin
                    m_lost_p[i] = 1;
                    if (m_drop[i] < 255) m_drop[i]++;
                end
            end
        end
        m_ts = (m_ts + 1) % 16;
    endtask

    // model advance and transfer log at each active edge
    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                model_clear();
            end else begin
                if (snap_valid && out_ready) xfer_q.push_back(snap);
                model_step();
            end
        end
    end

    // per-cycle comparison on the inactive edge
    initial begin
        forever begin
            @(negedge clk);
            snap_valid = out_valid;
            snap = '{int'(out_core), out_pc, out_insn, out_ts, out_lost};
            if (!reset) begin
                check("out_valid", 64'(out_valid), 64'(m_valid));
                if (m_valid) begin
                    check("out_core", 64'(out_core), 64'(m_out.core));
                    check("out_pc",   out_pc,        m_out.pc);
                    check("out_insn", 64'(out_insn), 64'(m_out.insn));
                    check("out_ts",   64'(out_ts),   64'(m_out.ts));
                    check("out_lost", 64'(out_lost), 64'(m_out.lost));
                end
                for (int i = 0; i < N; i++) begin
                    check($sformatf("drop_count[%0d]", i), 64'(drop_count[i*8 +: 8]), 64'(m_drop[i]));
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input int c, input logic [63:0] pc, input logic [31:0] insn);
        retire_valid[c]         = 1'b1;
        retire_pc[c*64 +: 64]   = pc;
        retire_insn[c*32 +: 32] = insn;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        retire_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        xfer_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        retire_valid = '0;
        retire_pc = '0;
        retire_insn = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_ts", 64'(out_ts), 64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        reset = 1'b0;

        // single event: core 2 sampled at ts=10
        repeat (10) tick();
        drive(2, 64'h8000_0000, 32'h0000_0013);
        tick();
        retire_valid = '0;
        check("single_idle", 64'(out_valid), 64'd0);
        tick();
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_core", 64'(out_core), 64'd2);
        check("single_ts", 64'(out_ts), 64'd10);
        check("single_lost", 64'(out_lost), 64'd0);
        check("single_pc", out_pc, 64'h8000_0000);
        tick();
        check("single_done", 64'(out_valid), 64'd0);
        enable = 1'b0;
        drive(0, 64'hDEAD, 32'h1);
        tick();
        retire_valid = '0;
        repeat (3) tick();
        check("enable_off_count", 64'(xfer_q.size()), 64'd1);
        enable = 1'b1;

        // fairness: two back-to-back all-core bursts
        do_reset();
        for (int c = 0; c < N; c++) drive(c, 64'h1000 + 64'(c), 32'h100 + 32'(c));
        tick();
        for (int c = 0; c < N; c++) drive(c, 64'h2000 + 64'(c), 32'h200 + 32'(c));
        tick();
        retire_valid = '0;
        repeat (10) tick();
        check("fair_count", 64'(xfer_q.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("fair_core%0d", k), 64'(xfer_q[k].core), 64'(k % 4));
            check($sformatf("fair_pc%0d", k), xfer_q[k].pc, ((k < 4) ? 64'h1000 : 64'h2000) + 64'(k % 4));
        end

        // overflow: core 0 holds the output, core 1 fills its FIFO and drops 3
        do_reset();
        out_ready = 1'b0;
        drive(0, 64'hC0, 32'h0);
        tick();
        for (int j = 1; j <= 11; j++) begin
            retire_valid = '0;
            drive(1, 64'h100 + 64'(j), 32'(j));
            tick();
        end
        retire_valid = '0;
        tick();
        check("ovf_drop1", 64'(drop_count[15:8]), 64'd3);
        out_ready = 1'b1;
        drive(1, 64'h10C, 32'd12);
        tick();
        retire_valid = '0;
        repeat (15) tick();
        check("ovf_count", 64'(xfer_q.size()), 64'd10);
        check("ovf_first_core", 64'(xfer_q[0].core), 64'd0);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("ovf_pc%0d", k), xfer_q[k].pc, 64'h100 + 64'(k));
            check($sformatf("ovf_lost%0d", k), 64'(xfer_q[k].lost), 64'd0);
        end
        check("ovf_9th_pc", xfer_q[9].pc, 64'h10C);
        check("ovf_9th_lost", 64'(xfer_q[9].lost), 64'd1);

        // backpressure: ready 1,0,0,1 while records are queued
        do_reset();
        out_ready = 1'b0;
        drive(1, 64'hA1, 32'h1);
        drive(3, 64'hB3, 32'h3);
        tick();
        retire_valid = '0;
        drive(1, 64'hC1, 32'h5);
        tick();
        retire_valid = '0;
        check("bp_first", out_pc, 64'hA1);
        out_ready = 1'b1;
        tick();
        check("bp_second", out_pc, 64'hB3);
        out_ready = 1'b0;
        tick();
        check("bp_hold1_pc", out_pc, 64'hB3);
        check("bp_hold1_core", 64'(out_core), 64'd3);
        tick();
        check("bp_hold2_pc", out_pc, 64'hB3);
        out_ready = 1'b1;
        tick();
        check("bp_third", out_pc, 64'hC1);
        repeat (4) tick();
        check("bp_count", 64'(xfer_q.size()), 64'd3);
        check("bp_order0", xfer_q[0].pc, 64'hA1);
        check("bp_order1", xfer_q[1].pc, 64'hB3);
        check("bp_order2", xfer_q[2].pc, 64'hC1);

        // timestamp wrap with 20 events, then drop-counter saturation
        do_reset();
        for (int j = 0; j < 20; j++) begin
            retire_valid = '0;
            drive(0, 64'h500 + 64'(j), 32'(j));
            tick();
        end
        retire_valid = '0;
        repeat (5) tick();
        check("wrap_count", 64'(xfer_q.size()), 64'd20);
        check("wrap_ts15", 64'(xfer_q[15].ts), 64'd15);
        check("wrap_ts16", 64'(xfer_q[16].ts), 64'd0);
        check("wrap_ts19", 64'(xfer_q[19].ts), 64'd3);
        out_ready = 1'b0;
        for (int j = 0; j < 309; j++) begin
            drive(0, 64'h900, 32'h0);
            tick();
        end
        retire_valid = '0;
        tick();
        check("sat_drop0", 64'(drop_count[7:0]), 64'd255);

        // reset mid-stream with 5 records queued behind a held output
        for (int j = 0; j < 5; j++) begin
            drive(2, 64'h600 + 64'(j), 32'(j));
            tick();
        end
        retire_valid = '0;
        tick();
        check("mid_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_drop", 64'(drop_count), 64'd0);
        check("mid_rst_ts", 64'(out_ts), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        xfer_q.delete();
        out_ready = 1'b1;
        repeat (3) tick();
        drive(0, 64'h700, 32'h33);
        tick();
        retire_valid = '0;
        check("post_rst_idle", 64'(out_valid), 64'd0);
        tick();
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_core", 64'(out_core), 64'd0);
        check("post_rst_ts", 64'(out_ts), 64'd3);
        check("post_rst_lost", 64'(out_lost), 64'd0);
        check("post_rst_pc", out_pc, 64'h700);
        repeat (3) tick();
        check("post_rst_count", 64'(xfer_q.size()), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
